// File: rtl/decoupled_fetch_unit_pkg.sv
// Shared types for the decoupled fetch unit: decode packet, in-flight request metadata, FSM states.
package decoupled_fetch_unit_pkg;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic        is_predicted;
        logic [31:0] predicted_target;
    } fetch_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        is_predicted;
        logic [31:0] predicted_target;
    } fetch_meta_t;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        ERROR = 2'd2
    } fetch_state_t;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

    function automatic logic pc_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/decoupled_fetch_unit_if.sv
// IMEM request/response and decode handshake bundle; master = fetch unit, slave = IMEM + decode side.
interface decoupled_fetch_unit_if;
    import decoupled_fetch_unit_pkg::*;

    logic [31:0] o_imem_addr;
    logic        o_imem_valid;
    logic        i_imem_ready;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_data;
    fetch_t      o_fetch_pkg;
    logic        o_fetch_valid;
    logic        i_fetch_ready;

    modport master (
        output o_imem_addr, o_imem_valid, o_fetch_pkg, o_fetch_valid,
        input  i_imem_ready, i_imem_rvalid, i_imem_data, i_fetch_ready
    );

    modport slave (
        input  o_imem_addr, o_imem_valid, o_fetch_pkg, o_fetch_valid,
        output i_imem_ready, i_imem_rvalid, i_imem_data, i_fetch_ready
    );

endinterface

// File: rtl/decoupled_fetch_unit_prim_sync_fifo.sv
// Synchronous FIFO with registered storage, synchronous clear, and push+pop legal at any fill level.
module prim_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_empty = (count_q == '0);
    assign o_full  = (count_q == CW'(DEPTH));
    assign o_count = count_q;
    assign o_rdata = mem_q[rd_ptr_q];

    // When full, a simultaneous pop frees the slot the push writes into.
    assign do_pop  = i_pop & ~o_empty & ~i_clear;
    assign do_push = i_push & (~o_full | do_pop) & ~i_clear;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (i_clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= i_wdata;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (do_pop) rd_ptr_q <= next_ptr(rd_ptr_q);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/decoupled_fetch_unit.sv
// Decoupled instruction fetch: credit-limited pipelined IMEM requests feeding a fetch queue.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module decoupled_fetch_unit
    import decoupled_fetch_unit_pkg::*;
#(
    parameter int          FQ_DEPTH        = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic                          i_clk,
    input  logic                          i_rstn,
    input  logic                          i_redirect_valid,
    input  logic [31:0]                   i_redirect_pc,
    output logic [31:0]                   o_prd_pc,
    input  logic                          i_prd_taken,
    input  logic [31:0]                   i_prd_target,
    decoupled_fetch_unit_if.master        bus,
    output logic                          o_error,
    output logic [31:0]                   o_perf_flush_cnt,
    output logic [31:0]                   o_perf_empty_cnt
);

    // state | meaning
    // INIT  | one idle cycle after reset, nothing issued
    // RUN   | issuing requests, filling the queue, accepting redirects
    // ERROR | misaligned redirect seen; everything frozen until reset

    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int QW = $clog2(FQ_DEPTH) + 1;
    localparam int MW = $bits(fetch_meta_t);
    localparam int FW = $bits(fetch_t);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [OW-1:0] outstanding_q, outstanding_d;
    logic [OW-1:0] drop_cnt_q, drop_cnt_d;

    logic run, redirect, issue, resp, live, fq_pop, credit_ok;
    logic imem_valid;

    fetch_meta_t  meta_wdata, meta_head;
    logic [OW-1:0] meta_count;
    logic         meta_full, meta_empty;

    fetch_t       fq_wdata, fq_head;
    logic [QW-1:0] fq_count;
    logic         fq_full, fq_empty;
    logic         fetch_valid;

    assign run         = (state_q == RUN);
    assign fetch_valid = run & ~fq_empty;

    // Credits count in-flight requests against queue space, so every response has a slot.
    assign credit_ok = (int'(outstanding_q) < MAX_OUTSTANDING) &&
                       ((int'(outstanding_q) + int'(fq_count)) < FQ_DEPTH);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        redirect      = run & i_redirect_valid;
        resp          = run & bus.i_imem_rvalid;
        live          = resp & (drop_cnt_q == '0) & ~redirect & ~meta_empty;
        imem_valid    = run & ~i_redirect_valid & credit_ok;
        issue         = imem_valid & bus.i_imem_ready;
        fq_pop        = fetch_valid & bus.i_fetch_ready & ~redirect;

        case (state_q)
            INIT:    state_d = RUN;
            RUN:     if (redirect && pc_misaligned(i_redirect_pc)) state_d = ERROR;
            ERROR:   state_d = ERROR;
            default: state_d = INIT;
        endcase

        outstanding_d = outstanding_q + OW'(issue) - OW'(resp);
        if (resp && drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - 1'b1;

        // Everything still in flight after this cycle belongs to the squashed path.
        if (redirect) begin
            pc_d       = i_redirect_pc;
            drop_cnt_d = outstanding_q - OW'(resp);
        end else if (issue) begin
            pc_d = i_prd_taken ? i_prd_target : pc_q + INSTR_BYTES;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q       <= INIT;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign meta_wdata = '{pc: pc_q, is_predicted: i_prd_taken, predicted_target: i_prd_target};

    prim_sync_fifo #(.WIDTH(MW), .DEPTH(MAX_OUTSTANDING)) u_meta_fifo (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_clear (redirect),
        .i_push  (issue),
        .i_wdata (meta_wdata),
        .i_pop   (live),
        .o_rdata (meta_head),
        .o_count (meta_count),
        .o_full  (meta_full),
        .o_empty (meta_empty)
    );

    assign fq_wdata = '{instr:            bus.i_imem_data,
                        pc:               meta_head.pc,
                        valid:            1'b1,
                        is_predicted:     meta_head.is_predicted,
                        predicted_target: meta_head.predicted_target};

    prim_sync_fifo #(.WIDTH(FW), .DEPTH(FQ_DEPTH)) u_fetch_queue (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_clear (redirect),
        .i_push  (live),
        .i_wdata (fq_wdata),
        .i_pop   (fq_pop),
        .o_rdata (fq_head),
        .o_count (fq_count),
        .o_full  (fq_full),
        .o_empty (fq_empty)
    );

    assign bus.o_imem_addr   = pc_q;
    assign bus.o_imem_valid  = imem_valid;
    assign bus.o_fetch_valid = fetch_valid;
    assign bus.o_fetch_pkg   = fetch_valid ? fq_head : '0;
    assign o_prd_pc          = pc_q;
    assign o_error           = (state_q == ERROR);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] flush_cnt_q, empty_cnt_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            flush_cnt_q <= '0;
            empty_cnt_q <= '0;
        end else begin
            if (redirect)        flush_cnt_q <= flush_cnt_q + 32'd1;
            if (run && fq_empty) empty_cnt_q <= empty_cnt_q + 32'd1;
        end
    end

    assign o_perf_flush_cnt = flush_cnt_q;
    assign o_perf_empty_cnt = empty_cnt_q;
`else
    assign o_perf_flush_cnt = 32'h0;
    assign o_perf_empty_cnt = 32'h0;
`endif

    a_resp_needs_outstanding: assert property (@(posedge i_clk) disable iff (!i_rstn)
        resp |-> (outstanding_q != '0));
    a_fq_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rstn)
        (live && fq_full) |-> fq_pop);
    a_meta_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rstn)
        issue |-> !meta_full);
    a_meta_within_outstanding: assert property (@(posedge i_clk) disable iff (!i_rstn)
        int'(meta_count) <= int'(outstanding_q));

endmodule

// File: tb/tb_decoupled_fetch_unit.sv
// Bench for decoupled_fetch_unit: random IMEM/decode/BPU/BRU traffic against an epoch-based fetch model.
module tb_decoupled_fetch_unit;
    import decoupled_fetch_unit_pkg::*;

    localparam int          FQ_DEPTH = 4;
    localparam int          MAX_OUT  = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic        i_redirect_valid = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic [31:0] o_prd_pc;
    logic        i_prd_taken = 1'b0;
    logic [31:0] i_prd_target = '0;
    logic        o_error;
    logic [31:0] o_perf_flush_cnt, o_perf_empty_cnt;

    decoupled_fetch_unit_if bus();

    decoupled_fetch_unit #(.FQ_DEPTH(FQ_DEPTH), .MAX_OUTSTANDING(MAX_OUT), .RESET_PC(RESET_PC)) dut (
        .i_clk            (i_clk),
        .i_rstn           (i_rstn),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .o_prd_pc         (o_prd_pc),
        .i_prd_taken      (i_prd_taken),
        .i_prd_target     (i_prd_target),
        .bus              (bus.master),
        .o_error          (o_error),
        .o_perf_flush_cnt (o_perf_flush_cnt),
        .o_perf_empty_cnt (o_perf_empty_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] tgt;
        int          epoch;
        int          cyc;
    } infl_t;

    // Model: requests in flight tagged with the redirect epoch they were issued in.
    infl_t       infl[$];
    fetch_t      expq[$];
    logic [31:0] m_pc;
    int          m_state;   // 0 idle-after-reset, 1 running, 2 error
    int          epoch, cyc;
    logic [31:0] m_flush, m_empty;

    int vectors = 0;
    int miscompares = 0;

    int k_ready, k_rvalid, k_fready, k_taken, k_redir;
    logic        force_redir = 1'b0;
    logic [31:0] force_rpc = '0;
    logic        pred_en = 1'b0;
    logic [31:0] pred_pc = '0, pred_tgt = '0;

    logic [31:0] issue_log[$];
    int          issue_cyc_log[$];
    logic [31:0] pop_log[$];
    fetch_t      pop_pkg_log[$];

    function automatic logic pct(input int p);
        return int'($urandom_range(99)) < p;
    endfunction

    function automatic logic [31:0] rand_aligned();
        logic [31:0] v;
        v = {22'd0, 8'($urandom_range(255)), 2'b00};
        return v;
    endfunction

    task automatic set_knobs(input int rdy, input int rv, input int frdy, input int tk, input int rd);
        k_ready = rdy; k_rvalid = rv; k_fready = frdy; k_taken = tk; k_redir = rd;
    endtask

    task automatic do_reset();
        i_rstn = 1'b0;
        i_redirect_valid = 1'b0;
        i_prd_taken = 1'b0;
        bus.i_imem_ready = 1'b0;
        bus.i_imem_rvalid = 1'b0;
        bus.i_imem_data = '0;
        bus.i_fetch_ready = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rstn = 1'b1;
        infl.delete(); expq.delete();
        m_pc = RESET_PC; m_state = 0; epoch = 0; cyc = 0;
        m_flush = '0; m_empty = '0;
        issue_log.delete(); issue_cyc_log.delete(); pop_log.delete(); pop_pkg_log.delete();
        pred_en = 1'b0; force_redir = 1'b0;
    endtask

    task automatic tick();
        logic redir_req, redir, run, exp_valid, exp_fv, issue, rv, pop;
        logic [31:0] rpc, exp_flush, exp_empty, data;
        fetch_t exp_pkg;
        infl_t  e;
        run       = (m_state == 1);
        redir_req = force_redir || pct(k_redir);
        rpc       = force_redir ? force_rpc : rand_aligned();
        force_redir = 1'b0;
        i_redirect_valid = redir_req;
        i_redirect_pc    = rpc;
        bus.i_imem_ready  = pct(k_ready);
        bus.i_fetch_ready = pct(k_fready);
        if (m_state == 2) rv = pct(k_rvalid);
        else              rv = (infl.size() > 0) && (infl[0].cyc < cyc) && pct(k_rvalid);
        data = $urandom;
        bus.i_imem_rvalid = rv;
        bus.i_imem_data   = data;
        if (pred_en) begin
            i_prd_taken  = (o_prd_pc == pred_pc);
            i_prd_target = pred_tgt;
        end else begin
            i_prd_taken  = pct(k_taken);
            i_prd_target = rand_aligned();
        end
        #1;
        redir     = redir_req && run;
        exp_valid = run && !redir && (infl.size() < MAX_OUT) && (infl.size() + expq.size() < FQ_DEPTH);
        exp_fv    = run && (expq.size() > 0);

        vectors++;
        if (bus.o_imem_valid !== exp_valid) begin
            miscompares++;
            $display("FAIL imem_valid cyc=%0d: got %b want %b", cyc, bus.o_imem_valid, exp_valid);
        end
        if (exp_valid) begin
            vectors++;
            if (bus.o_imem_addr !== m_pc) begin
                miscompares++;
                $display("FAIL imem_addr cyc=%0d: got %h want %h", cyc, bus.o_imem_addr, m_pc);
            end
        end
        if (m_state != 2) begin
            vectors++;
            if (o_prd_pc !== m_pc) begin
                miscompares++;
                $display("FAIL prd_pc cyc=%0d: got %h want %h", cyc, o_prd_pc, m_pc);
            end
        end
        vectors++;
        if (bus.o_fetch_valid !== exp_fv) begin
            miscompares++;
            $display("FAIL fetch_valid cyc=%0d: got %b want %b", cyc, bus.o_fetch_valid, exp_fv);
        end
        if (exp_fv) begin
            exp_pkg = expq[0];
            vectors++;
            if (bus.o_fetch_pkg !== exp_pkg) begin
                miscompares++;
                $display("FAIL fetch_pkg cyc=%0d: got %h want %h", cyc, bus.o_fetch_pkg, exp_pkg);
            end
        end
        vectors++;
        if (o_error !== (m_state == 2)) begin
            miscompares++;
            $display("FAIL error cyc=%0d: got %b want %b", cyc, o_error, (m_state == 2));
        end
`ifdef FETCH_PERF_CNT_EN
        exp_flush = m_flush; exp_empty = m_empty;
`else
        exp_flush = '0; exp_empty = '0;
`endif
        vectors++;
        if (o_perf_flush_cnt !== exp_flush || o_perf_empty_cnt !== exp_empty) begin
            miscompares++;
            $display("FAIL perf cyc=%0d: got %0d/%0d want %0d/%0d", cyc,
                     o_perf_flush_cnt, o_perf_empty_cnt, exp_flush, exp_empty);
        end

        issue = exp_valid && bus.i_imem_ready;
        pop   = exp_fv && bus.i_fetch_ready && !redir;
        if (issue) begin issue_log.push_back(bus.o_imem_addr); issue_cyc_log.push_back(cyc); end
        if (pop)   begin pop_log.push_back(bus.o_fetch_pkg.pc); pop_pkg_log.push_back(bus.o_fetch_pkg); end

        if (run) begin
            if (expq.size() == 0) m_empty++;
            if (redir) m_flush++;
            if (pop) void'(expq.pop_front());
            if (rv) begin
                e = infl.pop_front();
                if (!redir && e.epoch == epoch)
                    expq.push_back('{instr: data, pc: e.pc, valid: 1'b1,
                                     is_predicted: e.taken, predicted_target: e.tgt});
            end
            if (redir) begin
                expq.delete();
                m_pc = rpc;
                epoch++;
                if (rpc[1:0] != 2'b00) m_state = 2;
            end
            if (issue) begin
                infl.push_back('{pc: m_pc, taken: i_prd_taken, tgt: i_prd_target, epoch: epoch, cyc: cyc});
                m_pc = i_prd_taken ? i_prd_target : m_pc + 32'd4;
            end
        end else if (m_state == 0) begin
            m_state = 1;
        end
        cyc++;
        @(negedge i_clk);
    endtask

    task automatic test_reset();
        do_reset();
        set_knobs(80, 70, 60, 20, 5);
        repeat (20) tick();
        #2 i_rstn = 1'b0;
        #1;
        vectors++;
        if (bus.o_imem_valid !== 1'b0 || bus.o_fetch_valid !== 1'b0 || o_error !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got v=%b fv=%b err=%b want 0/0/0",
                     bus.o_imem_valid, bus.o_fetch_valid, o_error);
        end
        vectors++;
        if (bus.o_fetch_pkg !== '0) begin
            miscompares++;
            $display("FAIL reset_pkg: got %h want 0", bus.o_fetch_pkg);
        end
        vectors++;
        if (o_prd_pc !== RESET_PC) begin
            miscompares++;
            $display("FAIL reset_pc: got %h want %h", o_prd_pc, RESET_PC);
        end
        vectors++;
        if (o_perf_flush_cnt !== 32'h0 || o_perf_empty_cnt !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_perf: got %0d/%0d want 0/0", o_perf_flush_cnt, o_perf_empty_cnt);
        end
    endtask

    task automatic test_stream();
        logic [31:0] want;
        do_reset();
        set_knobs(100, 100, 100, 0, 0);
        repeat (12) tick();
        vectors++;
        if (issue_cyc_log.size() == 0 || issue_cyc_log[0] != 1) begin
            miscompares++;
            $display("FAIL first_issue_cycle: got %0d want 1",
                     issue_cyc_log.size() == 0 ? -1 : issue_cyc_log[0]);
        end
        for (int i = 0; i < 4; i++) begin
            want = 32'(i * 4);
            vectors++;
            if (issue_log.size() <= i || issue_log[i] !== want) begin
                miscompares++;
                $display("FAIL stream_issue[%0d]: got %h want %h", i,
                         issue_log.size() > i ? issue_log[i] : 32'hx, want);
            end
            vectors++;
            if (pop_log.size() <= i || pop_log[i] !== want) begin
                miscompares++;
                $display("FAIL stream_pop[%0d]: got %h want %h", i,
                         pop_log.size() > i ? pop_log[i] : 32'hx, want);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        set_knobs(100, 100, 0, 0, 0);
        repeat (20) tick();
        vectors++;
        if (issue_log.size() != FQ_DEPTH || bus.o_imem_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_issues: got %0d valid=%b want %0d valid=0",
                     issue_log.size(), bus.o_imem_valid, FQ_DEPTH);
        end
        set_knobs(100, 100, 100, 0, 0);
        repeat (30) tick();
        for (int i = 0; i < pop_log.size(); i++) begin
            vectors++;
            if (pop_log[i] !== 32'(i * 4)) begin
                miscompares++;
                $display("FAIL resume_pop[%0d]: got %h want %h", i, pop_log[i], 32'(i * 4));
            end
        end
        vectors++;
        if (pop_log.size() < 20) begin
            miscompares++;
            $display("FAIL resume_count: got %0d want >=20", pop_log.size());
        end
    endtask

    task automatic test_predict();
        logic [31:0] want [5];
        want = '{32'h0, 32'h4, 32'h8, 32'h40, 32'h44};
        do_reset();
        set_knobs(100, 100, 100, 0, 0);
        pred_en = 1'b1; pred_pc = 32'h8; pred_tgt = 32'h40;
        repeat (12) tick();
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (issue_log.size() <= i || issue_log[i] !== want[i]) begin
                miscompares++;
                $display("FAIL pred_issue[%0d]: got %h want %h", i,
                         issue_log.size() > i ? issue_log[i] : 32'hx, want[i]);
            end
        end
        vectors++;
        if (pop_pkg_log.size() < 3 || pop_pkg_log[2].pc !== 32'h8 || pop_pkg_log[2].is_predicted !== 1'b1 ||
            pop_pkg_log[2].predicted_target !== 32'h40) begin
            miscompares++;
            $display("FAIL pred_head: got %h want pc=8 pred=1 tgt=40",
                     pop_pkg_log.size() >= 3 ? pop_pkg_log[2] : '0);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        set_knobs(100, 0, 0, 0, 0);
        repeat (3) tick();
        vectors++;
        if (bus.o_imem_valid !== 1'b0 || infl.size() != 2) begin
            miscompares++;
            $display("FAIL pre_redirect: got valid=%b model_infl=%0d want 0/2", bus.o_imem_valid, infl.size());
        end
        issue_log.delete();
        force_redir = 1'b1; force_rpc = 32'h100;
        tick();
        set_knobs(100, 100, 100, 0, 0);
        repeat (10) tick();
        vectors++;
        if (issue_log.size() == 0 || issue_log[0] !== 32'h100) begin
            miscompares++;
            $display("FAIL redirect_issue: got %h want 100", issue_log.size() > 0 ? issue_log[0] : 32'hx);
        end
        vectors++;
        if (pop_log.size() == 0 || pop_log[0] !== 32'h100) begin
            miscompares++;
            $display("FAIL redirect_pop: got %h want 100", pop_log.size() > 0 ? pop_log[0] : 32'hx);
        end
    endtask

    task automatic test_error();
        int n;
        do_reset();
        set_knobs(100, 100, 100, 0, 0);
        repeat (5) tick();
        force_redir = 1'b1; force_rpc = 32'h102;
        tick();
        n = issue_log.size();
        set_knobs(100, 50, 100, 0, 0);
        repeat (12) tick();
        vectors++;
        if (o_error !== 1'b1 || issue_log.size() != n || bus.o_fetch_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL error_sticky: got err=%b new_issues=%0d fv=%b want 1/0/0",
                     o_error, issue_log.size() - n, bus.o_fetch_valid);
        end
    endtask

    task automatic test_perf();
        logic [31:0] want;
        do_reset();
        set_knobs(100, 100, 70, 0, 0);
        for (int r = 0; r < 3; r++) begin
            repeat (8) tick();
            force_redir = 1'b1; force_rpc = 32'(32'h200 + r * 32'h40);
            tick();
        end
        repeat (4) tick();
`ifdef FETCH_PERF_CNT_EN
        want = 32'd3;
`else
        want = 32'd0;
`endif
        vectors++;
        if (o_perf_flush_cnt !== want) begin
            miscompares++;
            $display("FAIL perf_flush: got %0d want %0d", o_perf_flush_cnt, want);
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 8; s++) begin
            do_reset();
            set_knobs(int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
                      int'($urandom_range(100, 20)), int'($urandom_range(40)), int'($urandom_range(8)));
            repeat (400) tick();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_predict();
        test_redirect();
        test_error();
        test_perf();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
